popcount_pattern_gen: RTL and testbench
=======================================

// Module: popcount_pattern_gen
// PURPOSE
//  Inverse of the switch-count adder: takes a 3-bit count {overflow,carry,sum}
//  and enumerates, in ascending binary order, every WIDTH-bit switch pattern
//  whose population count equals it. Patterns go out one at a time over a
//  valid/ready handshake. Used as a stimulus source for the counter and to
//  drive LED demo sequences.
// PARAMETERS
//  WIDTH  4  number of pattern bits (switches)
//  CW     3  count width, = clog2(WIDTH+1); count_in[CW-1:0]
// PORTS
//  clk            in   1      single clock, rising edge
//  rst_n          in   1      reset, synchronous, active-low
//  start          in   1      request enumeration; sampled only in IDLE
//  count_in       in   CW     target count; bit order {overflow,carry,sum} for WIDTH=4
//  pattern_out    out  WIDTH  current pattern; bit 3..0 = A,B,C,D
//  pattern_valid  out  1      pattern_out holds a valid pattern
//  pattern_ready  in   1      consumer accepts the pattern when valid&ready
//  busy           out  1      high in SCAN or EMIT
//  done           out  1      one-cycle pulse: enumeration finished
//  err            out  1      one-cycle pulse: start with count_in > WIDTH
// BEHAVIOUR
//  - Reset: rst_n=0 at a rising edge forces IDLE. All outputs read 0 (pattern_out,
//    pattern_valid, busy, done, err). Internal target=0, cand=0. Reset mid-run
//    aborts: no done pulse, and no further patterns until the next start.
//  - All outputs are registered.
//  - FSM states: IDLE, SCAN, EMIT, FIN.
//  - IDLE, start=1, count_in<=WIDTH: latch target=count_in, cand=0. Next state SCAN.
//  - IDLE, start=1, count_in>WIDTH: err=1 for the next cycle only. Stay IDLE.
//  - start in any state other than IDLE is ignored. count_in is only sampled at
//    accept time.
//  - SCAN tests one candidate per cycle:
//    popcount(cand)==target -> pattern_out<=cand, pattern_valid<=1, go EMIT.
//    else cand==all-ones -> go FIN.
//    else cand<=cand+1.
//  - EMIT holds pattern_out and pattern_valid stable until pattern_ready=1.
//    On valid&ready: pattern_valid<=0. Then if cand==all-ones go FIN,
//    else cand<=cand+1 and go SCAN.
//  - cand never wraps. All-ones is the last candidate tested.
//  - FIN: done=1 for exactly one cycle, busy=0. Next state IDLE.
//    start is not sampled in FIN.
//  - pattern_out keeps its last value when pattern_valid=0.
//  - Number of patterns emitted = C(WIDTH,target). For WIDTH=4: 1,4,6,4,1.
//  - Latency: start accepted at edge T -> first SCAN test at edge T+1.
//    Minimum gap between consecutive patterns is 2 cycles (EMIT->SCAN->EMIT).
//  - Worst case: the scan of all 2^WIDTH candidates finishes in 2^WIDTH cycles
//    of SCAN, plus the EMIT cycles and backpressure.
// TESTING
//  - count_in=3'b010, ready=1 always -> patterns 0011,0101,0110,1001,1010,1100
//    in that order, then one done pulse. busy drops at the edge where FIN is entered.
//  - count_in=3'b000 -> exactly one pattern 0000, then 15 SCAN cycles, then done.
//    count_in=3'b100 -> exactly one pattern 1111, then done.
//  - Backpressure: count_in=3'b001, ready low for 5 cycles on each pattern ->
//    pattern_out and valid stay stable while ready is low. Sequence
//    0001,0010,0100,1000, with no drops or duplicates.
//  - Error: count_in=3'b101 or 3'b111 with start -> err pulses one cycle.
//    valid, busy and done stay 0.
//  - Reset: rst_n=0 while in EMIT with count_in=3'b011 -> next cycle all outputs 0
//    and no done pulse. A fresh start then restarts from 0111.
//  - start held high throughout a run -> the run is not restarted. A new run
//    starts only after FIN returns to IDLE.

Source files
------------

// File: rtl/popcount_pattern_gen.sv
// popcount_pattern_gen: enumerates, in ascending order, every WIDTH-bit pattern whose popcount equals a requested count
module popcount_pattern_gen #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CW-1:0]    count_in_i,
  output logic [WIDTH-1:0] pattern_out_o,
  output logic             pattern_valid_o,
  input  logic             pattern_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;
  state_t           state_q;
  logic [CW-1:0]    target_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] pattern_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             hit;
  logic             last;
  logic [WIDTH-1:0] cand_d;
  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r = r + CW'(v[i]);
    return r;
  endfunction
  // candidate test: does it match the target, is it the final (all-ones) candidate, and its successor
  always_comb begin
    hit    = popcount(cand_q) == target_q;
    last   = &cand_q;
    cand_d = cand_q + WIDTH'(1);
  end
  // enumeration FSM; every output is a register, done/err are single-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      cand_q    <= '0;
      pattern_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE:
          if (start_i) begin
            if (count_in_i > CW'(WIDTH)) begin
              err_q <= 1'b1;
            end else begin
              target_q <= count_in_i;
              cand_q   <= '0;
              busy_q   <= 1'b1;
              state_q  <= SCAN;
            end
          end
        SCAN:
          if (hit) begin
            pattern_q <= cand_q;
            valid_q   <= 1'b1;
            state_q   <= EMIT;
          end else if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cand_q <= cand_d;
          end
        EMIT:
          if (pattern_ready_i) begin
            valid_q <= 1'b0;
            if (last) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              cand_q  <= cand_d;
              state_q <= SCAN;
            end
          end
        FIN:
          state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end
  assign pattern_out_o   = pattern_q;
  assign pattern_valid_o = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
endmodule

// File: tb/tb_popcount_pattern_gen.sv
// tb_popcount_pattern_gen: randomized scoreboard bench for popcount_pattern_gen
module tb_popcount_pattern_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cnt = 3'd0;
  logic [3:0] pat;
  logic       valid;
  logic       ready = 1'b1;
  logic       busy;
  logic       done;
  logic       err;
  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  bit         run_active = 1'b0;
  int         done_seen = 0;
  int         done_exp = 0;
  int         err_seen = 0;
  int         err_exp = 0;
  int         rmode = 0;
  int         bp = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic       pd = 1'b0;
  logic       pe = 1'b0;
  logic [3:0] ppat = 4'd0;

  popcount_pattern_gen #(.WIDTH(4), .CW(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .count_in_i(cnt),
    .pattern_out_o(pat),
    .pattern_valid_o(valid),
    .pattern_ready_i(ready),
    .busy_o(busy),
    .done_o(done),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int ones(input int v);
    int k = 0;
    for (int i = 0; i < 4; i++) k += (v >> i) & 1;
    return k;
  endfunction

  // ready driver: 0 always ready, 1 random, 2 five low cycles per pattern, 3 never ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        2: if (valid && bp < 5) begin ready = 1'b0; bp++; end
           else if (valid) begin ready = 1'b1; bp = 0; end
           else ready = 1'b0;
        default: ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every handshake and polices the protocol
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pd = 1'b0; pe = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", valid, 1);
        if (valid) chk("hold_pattern", pat, ppat);
      end
      if (valid) begin
        chk("busy_with_valid", busy, 1);
        if (ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_pattern actual=%b required=none", pat);
          end else begin
            chk("pattern", pat, exp_q.pop_front());
          end
        end
      end
      if (done) begin
        chk("done_single", pd, 0);
        chk("done_busy", busy, 0);
        checks++;
        if (!run_active) begin
          failures++;
          $display("FAIL done_unexpected actual=1 required=0");
        end
        chk("done_remaining", exp_q.size(), 0);
        run_active = 1'b0;
        done_seen++;
      end
      if (err) begin
        chk("err_single", pe, 0);
        err_seen++;
      end
      pv = valid; pr = ready; ppat = pat; pd = done; pe = err;
    end
  end

  task automatic set_mode(input int m);
    rmode = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_pattern", pat, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    exp_q.delete();
    run_active = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // one enumeration request, entered and left at posedge+1 with the DUT idle
  task automatic run(input int c, input bit hold);
    int n;
    int m;
    start = 1'b1;
    cnt = 3'(c);
    @(posedge clk);
    #1;
    start = hold;
    cnt = 3'($urandom_range(0, 7));
    if (c > 4) begin
      err_exp++;
      @(negedge clk);
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", valid, 0);
      chk("err_done", done, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      return;
    end
    m = 0;
    for (int p = 0; p < 16; p++)
      if (ones(p) == c) begin
        exp_q.push_back(4'(p));
        m++;
      end
    run_active = 1'b1;
    done_exp++;
    n = 0;
    while (run_active && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    checks++;
    if (run_active) begin
      failures++;
      $display("FAIL run_timeout actual=%0d required=<3000 count=%0d", n, c);
      run_active = 1'b0;
    end else if (rmode == 0) begin
      chk("run_cycles", n, 17 + m);
    end
    if (hold) begin
      repeat (3) begin
        @(negedge clk);
        chk("no_restart", busy, 0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap;
    #1;
    do_reset();
    run(2, 0);
    run(0, 0);
    run(4, 0);
    set_mode(2);
    run(1, 0);
    set_mode(0);
    run(5, 0);
    run(7, 0);
    set_mode(3);
    start = 1'b1;
    cnt = 3'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int p = 0; p < 16; p++) if (ones(p) == 3) exp_q.push_back(4'(p));
    run_active = 1'b1;
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_emit", valid, 1);
    snap = done_seen;
    do_reset();
    rmode = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_seen, snap);
    run(3, 0);
    run(2, 1);
    repeat (30) begin
      int c;
      set_mode(int'($urandom_range(0, 2)));
      c = int'($urandom_range(0, 7));
      run(c, c <= 4 && $urandom_range(0, 3) == 0);
    end
    set_mode(0);
    repeat (5) @(posedge clk);
    #1;
    chk("done_total", done_seen, done_exp);
    chk("err_total", err_seen, err_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
